// File: rtl/ysyx_22051013_axi_inst_rd.sv
// ysyx_22051013_axi_inst_rd -- single-beat AXI4 instruction read master (IDLE/ADDR/DATA/DONE).
// Rev 1.0
`default_nettype none

module ysyx_22051013_axi_inst_rd #(
  parameter logic [3:0] AXI_ID  = 4'b0000,
  parameter logic [2:0] AR_PROT = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_re,
  input  logic [63:0] axi_inst_pc,
  input  logic [2:0]  axi_size,
  output logic        axi_valid,
  output logic [63:0] axi_inst_i,
  output logic        resp_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [63:0] data_q;
  logic        err_q;

  logic        beat_ok;
  logic [63:0] rdata_aligned;

  // Only a last beat carrying our own ID completes the read; anything else is drained.
  assign beat_ok       = rvalid && (rid == AXI_ID) && rlast;
  assign rdata_aligned = rdata >> {addr_q[2:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 64'd0;
      size_q  <= 3'd0;
      data_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && axi_re) begin
        addr_q <= axi_inst_pc;
        size_q <= axi_size;
      end
      if (state_q == DATA && beat_ok) begin
        err_q  <= (rresp != 2'b00);
        data_q <= (rresp != 2'b00) ? 64'd0 : rdata_aligned;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    axi_valid = 1'b0;
    unique case (state_q)
      IDLE: if (axi_re) state_d = ADDR;
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (beat_ok) state_d = DONE;
      end
      DONE: begin
        axi_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // AR payload comes straight from the latched request, so it cannot move while stalled.
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;
  assign arprot  = AR_PROT;

  assign axi_inst_i = axi_valid ? data_q : 64'd0;
  assign resp_err   = axi_valid ? err_q : 1'b0;

endmodule

`default_nettype wire
